seg_display_driver: RTL and testbench
=====================================

# seg_display_driver

Board-level output stage that consumes the CPU's 8-bit external output bus and shows it on a 4-digit, common-anode, multiplexed seven-segment display. It converts the value to decimal with a sequential shift-add-3 converter, or shows it as hex in the alternate build. It scans the digits with a refresh counter on the fast board clock, not the slowed CPU clock. It sits directly downstream of the CPU board wrapper's `out` port.

## Interface
- `REFRESH_DIV`, default 100000: board clock cycles per digit slot; legal range ≥2.
- `clk` input 1: board clock (fast, undivided).
- `rst` input 1: reset; one clock domain, asynchronous, active-high.
- `value` input 8: unsigned value to display (CPU `ext_out`); quasi-static, may change at any clk edge.
- `seg` output 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` output 1: decimal point, active-low; always 1 (off).
- `an` output 4: digit anodes, active-low, one-hot-low; `an[0]` is the rightmost digit.
- `busy` output 1: conversion in progress.

## Operation
- Reset values:
  - `seg`=7'h7F, `dp`=1, `an`=4'hF, `busy`=0.
  - Digit registers, last-value register, slot index, refresh counter and FSM all 0 / IDLE.
  - After reset the display shows "0", because the last value is 0 and the digits are 0.
- Converter FSM states:
  - IDLE: on an edge where `value` ≠ last, latch `value` into the shift register, set last←`value`, clear the BCD accumulator and bit count, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each edge, add 3 to every BCD nibble ≥5, then shift `{bcd,bin}` left by 1. After the 8th shift, go to UPDATE.
  - UPDATE: copy hundreds/tens/ones into the digit registers and go to IDLE.
- `busy`=1 in SHIFT and UPDATE.
- `value` changes during SHIFT/UPDATE are ignored. On return to IDLE, a still-differing `value` starts a new conversion, so the final stable value is always displayed.
- BCD width: 10 bits (hundreds 2 bits, max 2). Arithmetic is unsigned; no overflow is possible for 0..255.
- Blanking:
  - Slot 3 is always blank.
  - Slot 2 (hundreds) is blank if hundreds = 0.
  - Slot 1 (tens) is blank if hundreds = 0 and tens = 0.
  - Slot 0 is always lit.
  - A blank slot drives `an`=4'hF and `seg`=7'h7F.
- Refresh:
  - The counter runs 0..`REFRESH_DIV`-1 continuously.
  - On wrap, the slot index increments mod 4 (3→0).
  - The scan is independent of the converter and is never stalled by it.
- Segment codes (active-low), for digits 0–9 and A–F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).

## Timing
- `seg` and `an` are registered and reflect the slot index and digit registers of the previous cycle: 1-cycle latency.
- Conversion latency, with the latch edge counted as edge 1:
  - Edges 2–9 are the 8 shifts.
  - Edge 10 (UPDATE) writes the digit registers.
  - Edge 11: `seg` reflects the new digit when that slot is active.
  - `busy` is high from after edge 1 until after edge 10 (9 cycles).
- Slot dwell is exactly `REFRESH_DIV` cycles; full scan period is 4×`REFRESH_DIV`.
- If UPDATE and a slot change fall on the same edge, both take effect; the new slot shows the new digit one cycle later.
- `rst` asserted mid-conversion immediately returns all state to reset values. The partial result is discarded, and the display shows "0" until `value` ≠ 0 triggers a conversion.

## Configuration
- `SEG_DECIMAL_EN` defined:
  - Decimal mode as above (shift-add-3 converter, 3 digits, leading-zero blanking).
- `SEG_DECIMAL_EN` undefined:
  - No converter is built.
  - On an edge where `value` ≠ last, the digit registers load hex nibbles directly (slot 1 = `value[7:4]`, slot 0 = `value[3:0]`) and last←`value`.
  - Latency: 1 edge to the digit registers, 2 edges to `seg`.
  - `busy` is tied to 0.
  - Slots 2 and 3 are always blank; no leading-zero blanking, so 8'h05 shows "05".

## Test plan
- Reset, `REFRESH_DIV`=4:
  - Required: `an`=F, `seg`=7F during reset.
  - After release: slot 0 shows `seg`=40 with `an`=E; slots 1–3 show `an`=F.
  - Each slot dwells 4 cycles.
- Decimal: `value`=255 →
  - `busy` is high 9 cycles.
  - Then slots 2/1/0 show `seg`=24/12/12 (digits 2, 5, 5).
  - Slot 3 stays blank.
- Decimal blanking: `value`=7 → slot 0 shows `seg`=78; slots 1, 2 and 3 are blank. `value`=40 → slots 1/0 show 19/40; slot 2 is blank.
- Mid-conversion change: `value`=100, then `value`=9 on the 3rd SHIFT cycle →
  - "100" is displayed briefly.
  - A second conversion starts immediately after UPDATE.
  - The display then shows only "9" (`seg`=10 on slot 0); `busy` covers 18 cycles total.
- Reset mid-conversion: `value`=200, assert `rst` on the 4th SHIFT cycle →
  - All outputs return to reset values.
  - After release with `value` still 200, a fresh conversion starts and "200" appears 10 edges later.
- Hex build (`SEG_DECIMAL_EN` undefined): `value`=8'hA5 →
  - Slots 1/0 show `seg`=08/12.
  - `busy` stays 0.
  - Slots 2 and 3 are blank.

Source files
------------

// File: rtl/seg_display_driver_if.sv
// rtl/seg_display_driver_if.sv - display bus between the CPU output port and the seven-segment driver
interface seg_display_driver_if;
    logic [7:0] value;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    // Source side: drives the value to show, observes the display pins
    modport master (
        output value,
        input  seg,
        input  dp,
        input  an,
        input  busy
    );

    // Driver side: consumes the value, drives the display pins
    modport slave (
        input  value,
        output seg,
        output dp,
        output an,
        output busy
    );
endinterface

// File: rtl/seg_display_driver.sv
// rtl/seg_display_driver.sv - 4-digit multiplexed seven-segment driver; SEG_DECIMAL_EN selects decimal (else hex)
module seg_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_display_driver_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       slot;
    logic [7:0]       last;
    logic [3:0]       dig0;
    logic [3:0]       dig1;
    logic [6:0]       seg_r;
    logic [3:0]       an_r;
    logic [3:0]       slot_digit;
    logic             slot_lit;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'h0: seg_code = 7'h40;
            4'h1: seg_code = 7'h79;
            4'h2: seg_code = 7'h24;
            4'h3: seg_code = 7'h30;
            4'h4: seg_code = 7'h19;
            4'h5: seg_code = 7'h12;
            4'h6: seg_code = 7'h02;
            4'h7: seg_code = 7'h78;
            4'h8: seg_code = 7'h00;
            4'h9: seg_code = 7'h10;
            4'hA: seg_code = 7'h08;
            4'hB: seg_code = 7'h03;
            4'hC: seg_code = 7'h46;
            4'hD: seg_code = 7'h21;
            4'hE: seg_code = 7'h06;
            default: seg_code = 7'h0E;
        endcase
    endfunction

    // Free-running refresh counter; advances the scan slot on every wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            slot        <= 2'd0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            slot        <= slot + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

`ifdef SEG_DECIMAL_EN
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;

    logic [1:0] state;
    logic [7:0] bin;
    logic [9:0] bcd;
    logic [2:0] bit_cnt;
    logic [3:0] dig2;
    logic [8:0] bcd_adj;

    // Add-3 correction on ones and tens; hundreds never exceeds 2 so it needs none
    always_comb begin
        bcd_adj = bcd[8:0];
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
    end

    // Shift-add-3 converter: latch on change, eight shifts, then publish digits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bin     <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            last    <= '0;
            dig0    <= '0;
            dig1    <= '0;
            dig2    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.value != last) begin
                        bin     <= bus.value;
                        last    <= bus.value;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd     <= {bcd_adj, bin[7]};
                    bin     <= {bin[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= UPDATE;
                end
                UPDATE: begin
                    dig2  <= {2'b00, bcd[9:8]};
                    dig1  <= bcd[7:4];
                    dig0  <= bcd[3:0];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);

    // Pick the digit for the current slot, suppressing leading zeros
    always_comb begin
        slot_digit = dig0;
        slot_lit   = 1'b0;
        case (slot)
            2'd0: begin
                slot_digit = dig0;
                slot_lit   = 1'b1;
            end
            2'd1: begin
                slot_digit = dig1;
                slot_lit   = (dig2 != 4'd0) || (dig1 != 4'd0);
            end
            2'd2: begin
                slot_digit = dig2;
                slot_lit   = (dig2 != 4'd0);
            end
            default: slot_lit = 1'b0;
        endcase
    end
`else
    // Hex mode: load both nibbles straight into the digit registers on change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= '0;
            dig0 <= '0;
            dig1 <= '0;
        end else if (bus.value != last) begin
            last <= bus.value;
            dig1 <= bus.value[7:4];
            dig0 <= bus.value[3:0];
        end
    end

    assign bus.busy = 1'b0;

    // Pick the digit for the current slot; only the two low slots are used
    always_comb begin
        slot_digit = dig0;
        slot_lit   = 1'b0;
        case (slot)
            2'd0: begin
                slot_digit = dig0;
                slot_lit   = 1'b1;
            end
            2'd1: begin
                slot_digit = dig1;
                slot_lit   = 1'b1;
            end
            default: slot_lit = 1'b0;
        endcase
    end
`endif

    // Register the pins so the anode and segment change together, glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= 7'h7F;
            an_r  <= 4'hF;
        end else if (slot_lit) begin
            seg_r <= seg_code(slot_digit);
            an_r  <= ~(4'b0001 << slot);
        end else begin
            seg_r <= 7'h7F;
            an_r  <= 4'hF;
        end
    end

    assign bus.seg = seg_r;
    assign bus.an  = an_r;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// tb/tb_seg_display_driver.sv - scoreboard bench for seg_display_driver against an arithmetic display model
module tb_seg_display_driver;
    localparam int RD = 4;

    typedef struct packed {
        logic [3:0]      lit;
        logic [3:0][6:0] s;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_display_driver_if bus();

    seg_display_driver #(.REFRESH_DIV(RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    frame_t     exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mon_busy = 1'b0;
    logic [6:0] code_tbl [16];
    logic [7:0] cur_val;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic frame_t model(input logic [7:0] v);
        frame_t f;
        int     d[4];
        int     iv;
        iv = int'(v);
`ifdef SEG_DECIMAL_EN
        d[0] = iv % 10;
        d[1] = (iv / 10) % 10;
        d[2] = iv / 100;
        d[3] = 0;
        f.lit = {1'b0, iv >= 100, iv >= 10, 1'b1};
`else
        d[0] = iv % 16;
        d[1] = iv / 16;
        d[2] = 0;
        d[3] = 0;
        f.lit = 4'b0011;
`endif
        for (int k = 0; k < 4; k++)
            f.s[k] = f.lit[k] ? code_tbl[d[k]] : 7'h7F;
        return f;
    endfunction

    // Monitor: for each expected frame, watch one full scan and compare slot by slot
    initial begin : monitor
        frame_t f;
        int     seen[4];
        int     segbad[4];
        int     blank_bad;
        int     bad_an;
        bit     hit;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                f = exp_q.pop_front();
                mon_busy = 1'b1;
                blank_bad = 0;
                bad_an = 0;
                for (int k = 0; k < 4; k++) begin
                    seen[k] = 0;
                    segbad[k] = 0;
                end
                repeat (4 * RD) begin
                    @(negedge clk);
                    if (bus.an == 4'hF) begin
                        if (bus.seg !== 7'h7F) blank_bad++;
                    end else begin
                        hit = 1'b0;
                        for (int k = 0; k < 4; k++) begin
                            if (bus.an == ~(4'b0001 << k)) begin
                                seen[k]++;
                                if (bus.seg !== f.s[k]) segbad[k]++;
                                hit = 1'b1;
                            end
                        end
                        if (!hit) bad_an++;
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("slot%0d_dwell", k), seen[k], f.lit[k] ? RD : 0);
                    check($sformatf("slot%0d_seg_errors(exp %0h)", k, f.s[k]), segbad[k], 0);
                end
                check("blank_seg_not_7f", blank_bad, 0);
                check("an_not_onehot", bad_an, 0);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic sync_monitor();
        int t = 0;
        while ((exp_q.size() != 0 || mon_busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("monitor_timeout", int'(t < 200), 1);
    endtask

    // Optionally drive a value, optionally change it mid-conversion, count busy cycles, then queue the expected frame
    task automatic run_case(input bit drive, input logic [7:0] v, input bit chg,
                            input logic [7:0] v2, input int exp_busy);
        int bc = 0;
        if (drive) begin
            @(posedge clk);
            #1 bus.value = v;
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (chg && i == 2) bus.value = v2;
            @(negedge clk);
            if (bus.busy) bc++;
        end
        check($sformatf("busy_cycles_v%0d", bus.value), bc, exp_busy);
        cur_val = bus.value;
        exp_q.push_back(model(bus.value));
        sync_monitor();
    endtask

    function automatic int busy_for(input logic [7:0] v, input logic [7:0] prev, input bit chg);
`ifdef SEG_DECIMAL_EN
        if (chg) return 18;
        return (v != prev) ? 9 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic check_reset_pins(input string tag);
        check({tag, "_an"}, bus.an, 4'hF);
        check({tag, "_seg"}, bus.seg, 7'h7F);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_dp"}, bus.dp, 1);
    endtask

    initial begin : stimulus
        logic [7:0] v;
        code_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        bus.value = 8'd0;
        cur_val = 8'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_pins("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Display after reset shows zero
        exp_q.push_back(model(8'd0));
        sync_monitor();

        // Directed values: full range, blanking cases, hex pattern
        run_case(1'b1, 8'd255, 1'b0, 8'd0, busy_for(8'd255, cur_val, 1'b0));
        run_case(1'b1, 8'd7,   1'b0, 8'd0, busy_for(8'd7,   cur_val, 1'b0));
        run_case(1'b1, 8'd40,  1'b0, 8'd0, busy_for(8'd40,  cur_val, 1'b0));
        run_case(1'b1, 8'hA5,  1'b0, 8'd0, busy_for(8'hA5,  cur_val, 1'b0));
        run_case(1'b1, 8'hA5,  1'b0, 8'd0, busy_for(8'hA5,  cur_val, 1'b0));

        // Value changes during the third shift; final value must win
        run_case(1'b1, 8'd100, 1'b1, 8'd9, busy_for(8'd100, cur_val, 1'b1));

        // Reset in the middle of a conversion, then reconvert the same value
        @(posedge clk);
        #1 bus.value = 8'd200;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_pins("midreset");
        repeat (2) @(negedge clk);
        check_reset_pins("midreset_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        run_case(1'b0, 8'd200, 1'b0, 8'd0, busy_for(8'd200, 8'd0, 1'b0));

        // Randomized values
        for (int n = 0; n < 10; n++) begin
            v = 8'($urandom_range(0, 255));
            run_case(1'b1, v, 1'b0, 8'd0, busy_for(v, cur_val, 1'b0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
